// File: rtl/pf_arbiter.sv
// pf_arbiter: two-master (data A, prefetch B) bus arbiter with alternating tie-break.
// Optional bus timeout with abort when PF_ARBITER_TIMEOUT_EN is defined.
module pf_arbiter #(
  parameter int AW = 28,
  parameter int DW = 32,
  parameter int TMO_CW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_stall,
  output logic          o_a_ack,
  output logic          o_a_err,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic [AW-1:0] i_b_addr,
  output logic          o_b_stall,
  output logic          o_b_ack,
  output logic          o_b_err,
  output logic [DW-1:0] o_rdata,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data
);
  typedef enum logic [1:0] {
    IDLE, OWN_A, OWN_B
`ifdef PF_ARBITER_TIMEOUT_EN
    , ABORT
`endif
  } state_e;

  if (TMO_CW < 1) begin : g_chk
    $error("pf_arbiter: TMO_CW must be at least 1");
  end

  state_e state_q, state_d;
  logic   lg_b_q, lg_b_d;
  logic   own_a, own_b, own_cyc, req_own, tmo, err_raw, ack_raw;

  assign own_a   = state_q == OWN_A;
  assign own_b   = state_q == OWN_B;
  assign own_cyc = own_a ? i_a_cyc : own_b ? i_b_cyc : 1'b0;
  // last-grant always names the current owner once the bus leaves IDLE
  assign req_own = lg_b_q ? i_b_cyc : i_a_cyc;

`ifdef PF_ARBITER_TIMEOUT_EN
  logic [TMO_CW-1:0] cnt_q, cnt_d;
  assign tmo   = own_cyc & (&cnt_q);
  assign cnt_d = (state_q == IDLE || (own_cyc && (i_wb_ack || err_raw))) ? '0 :
                 own_cyc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk) cnt_q <= i_reset ? '0 : cnt_d;
`else
  assign tmo = 1'b0;
`endif

  assign err_raw   = i_wb_err | tmo;
  assign ack_raw   = i_wb_ack & ~err_raw;
  assign o_a_ack   = own_a & i_a_cyc & ack_raw;
  assign o_a_err   = own_a & i_a_cyc & err_raw;
  assign o_b_ack   = own_b & i_b_cyc & ack_raw;
  assign o_b_err   = own_b & i_b_cyc & err_raw;
  assign o_a_stall = own_a ? i_wb_stall : 1'b1;
  assign o_b_stall = own_b ? i_wb_stall : 1'b1;
  assign o_wb_cyc  = own_cyc;
  assign o_wb_stb  = own_a ? i_a_cyc & i_a_stb : own_b ? i_b_cyc & i_b_stb : 1'b0;
  assign o_wb_we   = own_a & i_a_we;
  assign o_wb_addr = own_a ? i_a_addr : own_b ? i_b_addr : '0;
  assign o_wb_data = own_a ? i_a_data : '0;
  assign o_rdata   = i_wb_data;

  always_comb begin
    state_d = state_q;
    lg_b_d  = lg_b_q;
    if (state_q == IDLE) begin
      if (i_a_cyc && (!i_b_cyc || lg_b_q)) begin
        state_d = OWN_A;
        lg_b_d  = 1'b0;
      end else if (i_b_cyc) begin
        state_d = OWN_B;
        lg_b_d  = 1'b1;
      end
    end else if (!req_own) begin
      state_d = IDLE;
`ifdef PF_ARBITER_TIMEOUT_EN
    end else if (tmo) begin
      state_d = ABORT;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    state_q <= i_reset ? IDLE : state_d;
    lg_b_q  <= i_reset ? 1'b1 : lg_b_d;
  end
endmodule

// File: tb/tb_pf_arbiter.sv
// tb_pf_arbiter: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_pf_arbiter;
  localparam int AW = 28, DW = 32, TMO = 4;
`ifdef PF_ARBITER_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic a_cyc, a_stb, a_we, b_cyc, b_stb, wb_stall, wb_ack, wb_err;
  logic [AW-1:0] a_addr, b_addr, wb_addr;
  logic [DW-1:0] a_data, wb_rdata, rdata, wb_wdata;
  logic a_stall, a_ack, a_err, b_stall, b_ack, b_err, wb_cyc, wb_stb, wb_we;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  pf_arbiter #(.AW(AW), .DW(DW), .TMO_CW(TMO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
    .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_err(a_err),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_addr(b_addr),
    .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_err(b_err),
    .o_rdata(rdata), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {a_cyc, a_stb, a_we, b_cyc, b_stb, wb_stall, wb_ack, wb_err} = '0;
    a_addr = '0; b_addr = '0; a_data = '0; wb_rdata = '0;
  endtask

  // Model: owner 0=none 1=A 2=B; aborted marks a timed-out owner still holding cyc.
  int m_own, m_lg, m_cnt;
  bit m_abort, m_valid = 0;
  always @(negedge clk) begin
    bit live, ocyc, ostb, t, ecyc, eerr, eack;
    live = m_own != 0 && !m_abort;
    ocyc = m_own == 1 ? a_cyc : m_own == 2 ? b_cyc : 1'b0;
    ostb = m_own == 1 ? a_stb : b_stb;
    t    = TMO_ON && live && ocyc && m_cnt == (1 << TMO) - 1;
    ecyc = live && ocyc;
    eerr = ecyc && (wb_err || t);
    eack = ecyc && wb_ack && !eerr;
    if (m_valid) begin
      chk("wb_cyc", wb_cyc, ecyc);
      chk("wb_stb", wb_stb, ecyc && ostb);
      chk("wb_we", wb_we, live && m_own == 1 && a_we);
      chk("wb_addr", wb_addr, !live ? 0 : m_own == 1 ? a_addr : b_addr);
      chk("wb_data", wb_wdata, live && m_own == 1 ? a_data : 0);
      chk("rdata", rdata, wb_rdata);
      chk("a_stall", a_stall, live && m_own == 1 ? wb_stall : 1'b1);
      chk("b_stall", b_stall, live && m_own == 2 ? wb_stall : 1'b1);
      chk("a_ack", a_ack, m_own == 1 && eack);
      chk("a_err", a_err, m_own == 1 && eerr);
      chk("b_ack", b_ack, m_own == 2 && eack);
      chk("b_err", b_err, m_own == 2 && eerr);
    end
    if (rst) begin
      m_own = 0; m_abort = 0; m_lg = 2; m_cnt = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_own == 0) begin
        m_cnt = 0;
        if (a_cyc && b_cyc) m_own = m_lg == 2 ? 1 : 2;
        else if (a_cyc) m_own = 1;
        else if (b_cyc) m_own = 2;
        if (m_own != 0) m_lg = m_own;
      end else if (!(m_own == 1 ? a_cyc : b_cyc)) begin
        m_own = 0; m_abort = 0; m_cnt = 0;
      end else if (t) begin
        m_abort = 1; m_cnt = 0;
      end else if (!m_abort) m_cnt = (eack || eerr) ? 0 : m_cnt + 1;
    end
  end

  initial begin
    clr(); rst = 1; step(2);
    chk("rst_wb_cyc", wb_cyc, 0); chk("rst_a_stall", a_stall, 1); chk("rst_b_stall", b_stall, 1);
    rst = 0;
    // B read at 0x100, ack two cycles after grant
    b_cyc = 1; b_stb = 1; b_addr = 'h100; #1;
    chk("b_req_idle_cyc", wb_cyc, 0); chk("b_req_idle_stall", b_stall, 1);
    step();
    chk("b_grant_cyc", wb_cyc, 1); chk("b_grant_addr", wb_addr, 'h100); chk("b_grant_stall", b_stall, 0);
    b_stb = 0; step(2); wb_ack = 1; #1;
    chk("b_ack", b_ack, 1); chk("b_ack_a", a_ack, 0);
    step(); wb_ack = 0; b_cyc = 0; #1;
    chk("b_drop_cyc", wb_cyc, 0);
    step(); chk("b_idle_stall", b_stall, 1);
    // three back-to-back ties: A, B, A
    for (int i = 0; i < 3; i++) begin
      a_cyc = 1; b_cyc = 1; step();
      chk("tie_a_stall", a_stall, i == 1); chk("tie_b_stall", b_stall, i != 1);
      if (i == 1) b_cyc = 0; else a_cyc = 0;
      step();
    end
    clr(); step();
    // A writes while B waits; last grant is A so raise A first
    a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 'h44; a_data = 32'hDEADBEEF; step();
    b_cyc = 1; b_stb = 1; b_addr = 'h200;
    for (int i = 0; i < 3; i++) begin
      #1; chk("a_wr_b_stall", b_stall, 1); chk("a_wr_we", wb_we, 1); chk("a_wr_data", wb_wdata, 32'hDEADBEEF);
      step();
    end
    a_cyc = 0; a_stb = 0; step();
    chk("a_rel_idle_cyc", wb_cyc, 0); chk("a_rel_idle_bstall", b_stall, 1);
    step(); chk("b_after_a_stall", b_stall, 0); chk("b_after_a_we", wb_we, 0);
    // B aborts before ack; stray ack must not reach A
    b_cyc = 0; #1; chk("b_abort_cyc", wb_cyc, 0);
    step(); wb_ack = 1; a_cyc = 1; #1;
    chk("stray_a_ack", a_ack, 0); chk("stray_b_ack", b_ack, 0);
    step(); wb_ack = 0; #1; chk("a_after_stray", wb_cyc, 1);
    clr(); step();
    // silent slave
    a_cyc = 1; a_stb = 1; step();
    for (int i = 0; i < 20; i++) begin
      chk("tmo_err", a_err, TMO_ON && i == 15); chk("tmo_cyc", wb_cyc, !TMO_ON || i < 15);
      step();
    end
    clr(); step();
    // reset mid B transaction, then tie goes to A
    b_cyc = 1; b_stb = 1; step(); wb_ack = 1; rst = 1; step();
    chk("rst_mid_cyc", wb_cyc, 0); chk("rst_mid_bstall", b_stall, 1);
    chk("rst_mid_astall", a_stall, 1); chk("rst_mid_back", b_ack, 0);
    rst = 0; wb_ack = 0; a_cyc = 1; step();
    chk("rst_tie_a", a_stall, 0); chk("rst_tie_b", b_stall, 1);
    clr(); step();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) a_cyc = ~a_cyc;
      if ($urandom_range(7) == 0) b_cyc = ~b_cyc;
      a_stb = 1'($urandom); b_stb = 1'($urandom); a_we = 1'($urandom);
      a_addr = AW'($urandom); b_addr = AW'($urandom); a_data = $urandom; wb_rdata = $urandom;
      wb_stall = $urandom_range(3) == 0; wb_ack = $urandom_range(2) == 0;
      wb_err = $urandom_range(15) == 0; rst = $urandom_range(299) == 0;
      step();
    end
    rst = 0; clr(); step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
